// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
//
// Multi-cycle magnitude comparator. The operands are scanned MSB digit first,
// DIGIT bits per clock, and the block reports lt/gt/eq through a
// start/busy/done handshake. Both unsigned and two's-complement operands are
// supported.
//
// Handshake: start is sampled only while idle (busy=0). The operands and
// signed_mode are captured on that edge. busy stays high through the scan and
// the done cycle. done is a one-cycle pulse, and lt/gt/eq are valid from that
// cycle until the next result or reset. A start while busy is ignored.
//
// Optional build macro: SEQ_MAG_COMP_EARLY_EXIT_EN. When it is defined, the scan
// stops at the first differing digit. When it is undefined, every comparison
// takes exactly WIDTH/DIGIT scan cycles, so timing does not depend on the data.
//
// Parameters:
//   WIDTH        operand width in bits (>= 1)
//   DIGIT        bits compared per clock; must divide WIDTH
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        request a comparison (sampled while idle)
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   a, b         operands (sampled with start)
//   busy         high while scanning and during the done cycle
//   done         one-cycle result-valid pulse
//   lt, gt, eq   comparison result flags
// -----------------------------------------------------------------------------
module seq_mag_comp #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("seq_mag_comp: DIGIT must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sm_q, sm_d;
   logic             g_q, g_d, l_q, l_d;
   logic [CW-1:0]    count_q, count_d;
   logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;

   logic [DIGIT-1:0] dig_a, dig_b;
   logic             g_next, l_next;
   logic             finish_scan;

   always_comb begin
      // The operand registers shift left each scan cycle, so the digit under
      // test is always the top DIGIT bits.
      dig_a = a_q[WIDTH-1 -: DIGIT];
      dig_b = b_q[WIDTH-1 -: DIGIT];
      // Offset-binary trick: flipping the sign bit of the MSB digit turns a
      // signed comparison into an unsigned one.
      if (sm_q && (count_q == '0)) begin
         dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
         dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
      end
      // The first differing digit decides the result. After that, the flags are sticky.
      g_next = g_q | (~g_q & ~l_q & (dig_a > dig_b));
      l_next = l_q | (~g_q & ~l_q & (dig_a < dig_b));
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
      finish_scan = (count_q == LAST_COUNT) | g_next | l_next;
`else
      finish_scan = (count_q == LAST_COUNT);
`endif

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      g_d     = g_q;
      l_d     = l_q;
      count_d = count_q;
      lt_d    = lt_q;
      gt_d    = gt_q;
      eq_d    = eq_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sm_d    = signed_mode;
               g_d     = 1'b0;
               l_d     = 1'b0;
               count_d = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            a_d     = a_q << DIGIT;
            b_d     = b_q << DIGIT;
            g_d     = g_next;
            l_d     = l_next;
            count_d = count_q + CW'(1);
            if (finish_scan) begin
               lt_d    = l_next;
               gt_d    = g_next;
               eq_d    = ~(l_next | g_next);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         count_q <= '0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         g_q     <= g_d;
         l_q     <= l_d;
         count_q <= count_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign lt   = lt_q;
   assign gt   = gt_q;
   assign eq   = eq_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
//
// Testbench for seq_mag_comp. It drives two instances: an 8-bit unit with
// 1-bit digits and a 16-bit unit with 4-bit digits. The expected flags come
// from integer comparison of the operand values. The expected latency comes
// from counting digits of the operand values. The macro
// SEQ_MAG_COMP_EARLY_EXIT_EN selects which latency rule applies.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, lt8, gt8, eq8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, lt16, gt16, eq16;

   seq_mag_comp #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8),
      .lt(lt8), .gt(gt8), .eq(eq8)
   );

   seq_mag_comp #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .a(a16), .b(b16), .busy(busy16), .done(done16),
      .lt(lt16), .gt(gt16), .eq(eq16)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [2:0] exp_q[$];   // expected {lt,gt,eq} per launched comparison

   // ---------------- reference model ----------------
   function automatic longint to_val(input logic [15:0] v, input int w, input bit sm);
      longint r;
      r = longint'(v);
      if (sm && v[w-1]) r = r - (longint'(1) << w);
      return r;
   endfunction

   function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b,
                                            input int w, input bit sm);
      longint av, bv;
      av = to_val(a, w, sm);
      bv = to_val(b, w, sm);
      if (av < bv) return 3'b100;
      if (av > bv) return 3'b010;
      return 3'b001;
   endfunction

   // Number of cycles from the start edge to the cycle where done is high.
   function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b,
                                  input int w, input int d, input bit sm);
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
      longint ao, bo, mask, da, db, bias;
      bias = sm ? (longint'(1) << (w - 1)) : 0;
      ao   = to_val(a, w, sm) + bias;   // map the value range onto 0 .. 2^w-1
      bo   = to_val(b, w, sm) + bias;
      mask = (longint'(1) << d) - 1;
      for (int i = 0; i < w / d; i++) begin
         da = (ao >> (w - (i + 1) * d)) & mask;
         db = (bo >> (w - (i + 1) * d)) & mask;
         if (da != db) return i + 2;
      end
`endif
      return w / d + 1;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_cmp(input bit wide, input logic [15:0] a, input logic [15:0] b,
                            input logic sm, output int lat, output int busy_cyc,
                            output logic [2:0] flags, output bit timed_out);
      @(negedge clk);
      if (wide) begin
         start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
      end else begin
         start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      start16 = 1'b0;
      lat = 0; busy_cyc = 0; flags = '0; timed_out = 1'b0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (wide ? busy16 : busy8) busy_cyc++;
         if (wide ? done16 : done8) begin
            flags = wide ? {lt16, gt16, eq16} : {lt8, gt8, eq8};
            break;
         end
         if (lat > 100) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy8, done8, lt8, gt8, eq8} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_8: got %b expected 00000", {busy8, done8, lt8, gt8, eq8});
      end
      n_checks++;
      if ({busy16, done16, lt16, gt16, eq16} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_16: got %b expected 00000", {busy16, done16, lt16, gt16, eq16});
      end
      rst = 1'b1;
   endtask

   task automatic test_equal();
      int lat, bc; logic [2:0] fl, ex; bit to;
      exp_q.push_back(ref_flags(16'h5A, 16'h5A, 8, 1'b0));
      drive_cmp(1'b0, 16'h5A, 16'h5A, 1'b0, lat, bc, fl, to);
      ex = exp_q.pop_front();
      n_checks++;
      if (to || fl !== ex) begin
         n_errors++;
         $display("FAIL equal_flags: got %b timeout %0d expected %b", fl, to, ex);
      end
      n_checks++;
      if (lat !== 9) begin
         n_errors++;
         $display("FAIL equal_latency: got %0d expected 9", lat);
      end
      n_checks++;
      if (bc !== 9) begin
         n_errors++;
         $display("FAIL equal_busy_cycles: got %0d expected 9", bc);
      end
      @(negedge clk);
      n_checks++;
      if ({busy8, done8} !== 2'b00) begin
         n_errors++;
         $display("FAIL after_done_idle: got busy/done %b expected 00", {busy8, done8});
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({lt8, gt8, eq8} !== ex) begin
         n_errors++;
         $display("FAIL flags_hold: got %b expected %b", {lt8, gt8, eq8}, ex);
      end
   endtask

   task automatic test_signed();
      logic [7:0] ta[3] = '{8'h80, 8'h80, 8'hFF};
      logic [7:0] tb[3] = '{8'h7F, 8'h7F, 8'h01};
      bit         ts[3] = '{1'b0, 1'b1, 1'b1};
      logic [2:0] te[3] = '{3'b010, 3'b100, 3'b100};
      int lat, bc; logic [2:0] fl, ex; bit to;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(ref_flags({8'h00, ta[i]}, {8'h00, tb[i]}, 8, ts[i]));
         drive_cmp(1'b0, {8'h00, ta[i]}, {8'h00, tb[i]}, ts[i], lat, bc, fl, to);
         ex = exp_q.pop_front();
         n_checks++;
         if (to || fl !== te[i] || fl !== ex) begin
            n_errors++;
            $display("FAIL signed_%0d: got %b expected %b", i, fl, te[i]);
         end
      end
   endtask

   task automatic test_wide();
      logic [15:0] ta[2] = '{16'h1234, 16'hFFFF};
      logic [15:0] tb[2] = '{16'h1235, 16'h0000};
      logic [2:0]  te[2] = '{3'b100, 3'b010};
      int lat, bc, el; logic [2:0] fl; bit to;
      for (int i = 0; i < 2; i++) begin
         drive_cmp(1'b1, ta[i], tb[i], 1'b0, lat, bc, fl, to);
         el = exp_lat(ta[i], tb[i], 16, 4, 1'b0);
         n_checks++;
         if (to || fl !== te[i]) begin
            n_errors++;
            $display("FAIL wide_flags_%0d: got %b expected %b", i, fl, te[i]);
         end
         n_checks++;
         if (lat !== el) begin
            n_errors++;
            $display("FAIL wide_latency_%0d: got %0d expected %0d", i, lat, el);
         end
      end
   endtask

   task automatic test_random();
      int lat, bc, el; logic [2:0] fl, ex; bit to, sm, wide;
      logic [15:0] ra, rb;
      for (int i = 0; i < 60; i++) begin
         wide = (i % 3 == 2);
         sm   = 1'($urandom_range(0, 1));
         ra   = 16'($urandom);
         rb   = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
         if (!wide) begin
            ra[15:8] = '0;
            rb[15:8] = '0;
         end
         exp_q.push_back(ref_flags(ra, rb, wide ? 16 : 8, sm));
         el = exp_lat(ra, rb, wide ? 16 : 8, wide ? 4 : 1, sm);
         drive_cmp(wide, ra, rb, sm, lat, bc, fl, to);
         ex = exp_q.pop_front();
         n_checks++;
         if (to || fl !== ex || lat !== el) begin
            n_errors++;
            $display("FAIL random_%0d: a=%h b=%h sm=%0d got flags %b lat %0d expected %b lat %0d",
                     i, ra, rb, sm, fl, lat, ex, el);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [2:0] fl;
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sm8 = 1'b0;
      @(posedge clk);
      #1;
      lat = 0; fl = '0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
         if (done8) begin
            fl = {lt8, gt8, eq8};
            break;
         end
      end
      n_checks++;
      if (fl !== 3'b100 || lat !== exp_lat(16'h10, 16'h20, 8, 1, 1'b0)) begin
         n_errors++;
         $display("FAIL b2b_first: got flags %b lat %0d expected 100 lat %0d",
                  fl, lat, exp_lat(16'h10, 16'h20, 8, 1, 1'b0));
      end
      @(negedge clk);   // start still high: DONE must return to idle first
      n_checks++;
      if (busy8 !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_idle_gap: got busy %b expected 0", busy8);
      end
      a8 = 8'h50; b8 = 8'h40; sm8 = 1'b0;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      lat = 0; fl = '0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done8) begin
            fl = {lt8, gt8, eq8};
            break;
         end
      end
      n_checks++;
      if (fl !== 3'b010 || lat !== exp_lat(16'h50, 16'h40, 8, 1, 1'b0)) begin
         n_errors++;
         $display("FAIL b2b_second: got flags %b lat %0d expected 010", fl, lat);
      end
   endtask

   task automatic test_reset_mid_scan();
      int lat, bc, seen; logic [2:0] fl; bit to;
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hC3; b8 = 8'h3C; sm8 = 1'b0;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy8, done8, lt8, gt8, eq8} !== 5'b0) begin
         n_errors++;
         $display("FAIL mid_scan_reset: got %b expected 00000", {busy8, done8, lt8, gt8, eq8});
      end
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_errors++;
         $display("FAIL aborted_scan_resumed: got %0d active cycles expected 0", seen);
      end
      drive_cmp(1'b0, 16'h3C, 16'hC3, 1'b0, lat, bc, fl, to);
      n_checks++;
      if (to || fl !== 3'b100) begin
         n_errors++;
         $display("FAIL after_reset_cmp: got %b expected 100", fl);
      end
   endtask

   task automatic test_early_exit();
      int lat, bc, el; logic [2:0] fl; bit to;
      drive_cmp(1'b0, 16'h80, 16'h00, 1'b0, lat, bc, fl, to);
      el = exp_lat(16'h80, 16'h00, 8, 1, 1'b0);
      n_checks++;
      if (to || fl !== 3'b010 || lat !== el) begin
         n_errors++;
         $display("FAIL early_msb_diff: got flags %b lat %0d expected 010 lat %0d", fl, lat, el);
      end
      drive_cmp(1'b0, 16'h33, 16'h33, 1'b0, lat, bc, fl, to);
      n_checks++;
      if (to || fl !== 3'b001 || lat !== 9) begin
         n_errors++;
         $display("FAIL early_equal: got flags %b lat %0d expected 001 lat 9", fl, lat);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_equal();
      test_signed();
      test_wide();
      test_random();
      test_back_to_back();
      test_reset_mid_scan();
      test_early_exit();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
